// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the multi-channel NCO clock-enable generator.
package clkgen_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} fsm_t;

  function automatic int lock_cnt_w(input int cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles);
  endfunction

  localparam int LOCK_CYCLES_DFLT = 1024;
  localparam int LOCK_CNT_W       = lock_cnt_w(LOCK_CYCLES_DFLT);

  // inc = f_out * 2^acc_w / f_ref, widened so acc_w up to 48 cannot overflow
  function automatic logic [63:0] calc_inc(input longint unsigned f_ref_hz,
                                           input longint unsigned f_out_hz,
                                           input int acc_w);
    logic [127:0] num;
    num = 128'(f_out_hz) << acc_w;
    return 64'(num / 128'(f_ref_hz));
  endfunction

endpackage

// File: rtl/clkgen_nco_ch.sv
// One NCO channel: shadow inc/phase, live accumulator, carry enable, optional square out.
// Square output is built only when CLKGEN_SQUARE_OUT_EN is defined.
module clkgen_nco_ch #(
  parameter int ACC_W = 32
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [ACC_W-1:0] wr_inc,
  input  logic [ACC_W-1:0] wr_phase,
  input  logic             apply,
  output logic             ce,
  output logic             clk_out
);

  logic [ACC_W-1:0] shadow_inc, shadow_phase, inc, acc;
  logic [ACC_W-1:0] inc_nx, phase_nx;
  logic [ACC_W:0]   sum;

  // a write in the apply cycle is forwarded straight into the live NCO
  assign inc_nx   = wr_en ? wr_inc   : shadow_inc;
  assign phase_nx = wr_en ? wr_phase : shadow_phase;
  assign sum      = {1'b0, acc} + {1'b0, inc};

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_inc   <= '0;
      shadow_phase <= '0;
      inc          <= '0;
      acc          <= '0;
      ce           <= 1'b0;
    end else begin
      shadow_inc   <= inc_nx;
      shadow_phase <= phase_nx;
      if (apply) begin
        inc <= inc_nx;
        acc <= phase_nx;
        ce  <= 1'b0;
      end else begin
        acc <= sum[ACC_W-1:0];
        ce  <= sum[ACC_W];
      end
    end
  end

`ifdef CLKGEN_SQUARE_OUT_EN
  logic msb_q;
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) msb_q <= 1'b0;
    else        msb_q <= acc[ACC_W-1];
  end
  assign clk_out = msb_q;
`else
  assign clk_out = 1'b0;
`endif

endmodule

// File: rtl/clkgen_nco_multi.sv
// Multi-channel NCO clock-enable generator: config decode, apply/lock FSM, channel array.
// Optional square outputs via CLKGEN_SQUARE_OUT_EN. rst_n is assumed released synchronously to refclk.
module clkgen_nco_multi
  import clkgen_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 1024,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic              cfg_apply,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ce_out,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);

  localparam int              CNT_W    = lock_cnt_w(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  fsm_t             state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             wr_fire, ch_ok;

  assign wr_fire = cfg_valid & cfg_ready;
  assign ch_ok   = 32'(cfg_ch) < 32'(NUM_CH);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
    end else begin
      cfg_ready <= ~cfg_apply;
      cfg_err   <= wr_fire & ~ch_ok;
      state     <= state_nx;
      cnt       <= cnt_nx;
    end
  end

  // counter stops at CNT_LAST on entering LOCKED, which is its saturation point
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE:   ;
      SETTLE: if (cnt == CNT_LAST) state_nx = LOCKED;
              else                 cnt_nx   = cnt + CNT_W'(1);
      LOCKED: ;
      default: state_nx = IDLE;
    endcase
    if (cfg_apply) begin
      state_nx = SETTLE;
      cnt_nx   = '0;
    end
  end

  assign locked = (state == LOCKED);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clkgen_nco_ch #(.ACC_W(ACC_W)) u_ch (
      .refclk   (refclk),
      .rst_n    (rst_n),
      .wr_en    (wr_fire && (32'(cfg_ch) == i)),
      .wr_inc   (cfg_inc),
      .wr_phase (cfg_phase),
      .apply    (cfg_apply),
      .ce       (ce_out[i]),
      .clk_out  (clk_out[i])
    );
  end

endmodule

// File: tb/tb_clkgen_nco_multi.sv
// Bench for clkgen_nco_multi: per-cycle behavioural model plus directed literal checks.
module tb_clkgen_nco_multi;
  import clkgen_pkg::*;

  localparam int NCH = 3;
  localparam int AW  = 32;
  localparam int LCK = 16;

  logic           refclk;
  logic           rst_n;
  logic           cfg_valid, cfg_ready, cfg_apply, cfg_err, locked;
  logic [1:0]     cfg_ch;
  logic [AW-1:0]  cfg_inc, cfg_phase;
  logic [NCH-1:0] ce_out, clk_out;

  int checks = 0;
  int errors = 0;

  clkgen_nco_multi #(.NUM_CH(NCH), .ACC_W(AW), .LOCK_CYCLES(LCK)) dut (
    .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_phase(cfg_phase), .cfg_apply(cfg_apply),
    .cfg_err(cfg_err), .ce_out(ce_out), .clk_out(clk_out), .locked(locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // ---------------- behavioural model ----------------
  logic [AW-1:0]  m_sh_inc[NCH], m_sh_ph[NCH], m_inc[NCH], m_acc[NCH];
  logic [NCH-1:0] m_ce, m_clk;
  bit             m_ready, m_err, m_applied;
  int             m_since;

  task automatic model_step();
    logic [AW:0] sum;
    bit fire;
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_sh_inc[i] = '0; m_sh_ph[i] = '0; m_inc[i] = '0; m_acc[i] = '0;
      end
      m_ce = '0; m_clk = '0; m_ready = 0; m_err = 0; m_applied = 0; m_since = 0;
      return;
    end
    fire  = cfg_valid && m_ready;
    m_err = fire && (cfg_ch >= NCH);
    if (fire && cfg_ch < NCH) begin
      m_sh_inc[cfg_ch] = cfg_inc;
      m_sh_ph[cfg_ch]  = cfg_phase;
    end
    for (int i = 0; i < NCH; i++) begin
      m_clk[i] = m_acc[i][AW-1];
      if (cfg_apply) begin
        m_inc[i] = m_sh_inc[i];
        m_acc[i] = m_sh_ph[i];
        m_ce[i]  = 1'b0;
      end else begin
        sum      = {1'b0, m_acc[i]} + {1'b0, m_inc[i]};
        m_ce[i]  = sum[AW];
        m_acc[i] = sum[AW-1:0];
      end
    end
    if (cfg_apply) begin
      m_since = 0; m_applied = 1;
    end else if (m_since < 100000) begin
      m_since++;
    end
    m_ready = !cfg_apply;
  endtask

  initial forever begin
    @(posedge refclk or negedge rst_n);
    model_step();
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge refclk);
    chk("m_ce_out", ce_out, m_ce);
`ifdef CLKGEN_SQUARE_OUT_EN
    chk("m_clk_out", clk_out, m_clk);
`else
    chk("m_clk_out", clk_out, '0);
`endif
    chk("m_locked", locked, m_applied && (m_since >= LCK));
    chk("m_cfg_ready", cfg_ready, m_ready);
    chk("m_cfg_err", cfg_err, m_err);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(); @(negedge refclk); endtask

  task automatic write(input logic [1:0] ch, input logic [AW-1:0] inc, input logic [AW-1:0] ph);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_inc = inc; cfg_phase = ph;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic apply();
    cfg_apply = 1'b1;
    tick();
    cfg_apply = 1'b0;
  endtask

  logic [AW-1:0] quarter;

  initial begin
    quarter   = AW'(calc_inc(64'd100_000_000, 64'd25_000_000, AW));
    cfg_valid = 0; cfg_apply = 0; cfg_ch = 0; cfg_inc = 0; cfg_phase = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk("rst_ce", ce_out, 0);
    chk("rst_ready", cfg_ready, 0);
    repeat (3) tick();
    rst_n = 1'b1;

    // idle after reset: no enables, no lock, ready from first cycle
    tick();
    chk("t1_ready_cyc1", cfg_ready, 1);
    for (int k = 0; k < 100; k++) begin
      tick();
      chk("t1_ce_idle", ce_out, 0);
      chk("t1_locked_idle", locked, 0);
    end

    // periods 4 and 2, lock at exactly 16 cycles
    write(2'd0, quarter, 32'h0);
    write(2'd1, 32'h8000_0000, 32'h0);
    apply();
    chk("t2_ce_k0", ce_out, 0);
    chk("t2_ready_k0", cfg_ready, 0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("t2_ce0", ce_out[0], (k % 4) == 0);
      chk("t2_ce1", ce_out[1], (k % 2) == 0);
      chk("t2_locked", locked, k >= LCK);
    end

    // start phase: ch0 fires 1 cycle after apply, ch2 after 4
    write(2'd0, 32'h4000_0000, 32'hC000_0000);
    write(2'd2, 32'h4000_0000, 32'h0);
    apply();
    chk("t3_unlock_k0", locked, 0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k <= 6) begin
        chk("t3_ce0", ce_out[0], (k % 4) == 1);
        chk("t3_ce2", ce_out[2], (k % 4) == 0);
      end
    end
    chk("t3_relocked", locked, 1);

    // re-apply 8 cycles into SETTLE restarts the lock count
    apply();
    chk("t4_unlock_k0", locked, 0);
    repeat (7) tick();
    apply();
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) chk("t4_locked_k15", locked, 0);
      if (k == 16) chk("t4_locked_k16", locked, 1);
    end

    // out-of-range channel: error pulse, shadow untouched
    write(2'd3, 32'hDEAD_BEEF, 32'h1234_5678);
    chk("t5_err_pulse", cfg_err, 1);
    tick();
    chk("t5_err_clear", cfg_err, 0);
    apply();
    tick();
    chk("t5_ch0_phase_kept", ce_out[0], 1);
    repeat (4) tick();

    // write and apply in the same cycle: new inc live at once
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_inc = 32'h2000_0000; cfg_phase = 32'h0;
    cfg_apply = 1'b1;
    tick();
    cfg_valid = 1'b0; cfg_apply = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t5_fwd_ce1", ce_out[1], k == 8);
    end
    repeat (12) tick();
    chk("t6_locked_before_rst", locked, 1);

    // async reset mid-LOCKED
    @(posedge refclk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ce", ce_out, 0);
    chk("t6_rst_clk", clk_out, 0);
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_ready", cfg_ready, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("t6_ce_after_rst", ce_out, 0);
    end
    apply();
    for (int k = 1; k <= LCK; k++) begin
      tick();
      chk("t6_ce_zero_inc", ce_out, 0);
    end
    chk("t6_lock_zero_inc", locked, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
